// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, branch redirect
// and a sticky fault state for misaligned branch targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    output logic             imem_en,
    input  logic [31:0]      imem_data,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, FLT} state_e;

    state_e           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic [31:0]      pc4_q;
    logic             valid_q;
    logic             fault_q;
    logic             en_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      pc_d;
    logic [CNT_W-1:0] cnt_d;

    // PC+4 wraps naturally at 2^32; the counter saturates instead of wrapping.
    assign pc_d  = pc_q + 32'd4;
    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            en_q    <= 1'b1;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    // A redirect wins over stall and squashes the wrong-path fetch.
                    if (branch_taken) begin
                        valid_q <= 1'b0;
                        if (branch_target[1:0] == 2'b00) begin
                            pc_q <= branch_target;
                        end else begin
                            state_q <= FLT;
                            fault_q <= 1'b1;
                            en_q    <= 1'b0;
                        end
                    end else if (!stall) begin
                        instr_q <= imem_data;
                        pc4_q   <= pc_d;
                        valid_q <= 1'b1;
                        pc_q    <= pc_d;
                        cnt_q   <= cnt_d;
                    end
                end
                FLT: valid_q <= 1'b0;
                default: begin
                    state_q <= BOOT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr  = pc_q;
    assign imem_en    = en_q;
    assign ifid_instr = instr_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_valid = valid_q;
    assign fault      = fault_q;
    assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver updates an abstract model and queues
// expected outputs; a negedge monitor pops and compares against two instances.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, stall, branch_taken;
    logic [31:0] branch_target;

    logic [31:0] imem_addr, imem_data, ifid_instr, ifid_pc4;
    logic        imem_en, ifid_valid, fault;
    logic [15:0] fetch_cnt;

    logic [31:0] imem_addr2, imem_data2, ifid_instr2, ifid_pc42;
    logic        imem_en2, ifid_valid2, fault2;
    logic [1:0]  fetch_cnt2;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign imem_data  = mem_word(imem_addr);
    assign imem_data2 = mem_word(imem_addr2);

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_data(imem_data), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
        .ifid_valid(ifid_valid), .fault(fault), .fetch_cnt(fetch_cnt)
    );

    fetch_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr2), .imem_en(imem_en2),
        .imem_data(imem_data2), .ifid_instr(ifid_instr2), .ifid_pc4(ifid_pc42),
        .ifid_valid(ifid_valid2), .fault(fault2), .fetch_cnt(fetch_cnt2)
    );

    typedef struct {
        logic [31:0] addr, instr, pc4;
        logic        en, v, flt;
        int          cnt;
    } exp_t;
    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Abstract model: booting / faulted flags plus architectural values
    bit          m_booting, m_faulted;
    logic [31:0] m_pc, m_instr, m_pc4;
    bit          m_v;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit s, input bit b, input logic [31:0] t);
        exp_t e;
        rst_n = r; stall = s; branch_taken = b; branch_target = t;
        if (!r) begin
            m_booting = 1; m_faulted = 0; m_pc = 32'h0;
            m_instr = 0; m_pc4 = 0; m_v = 0; m_cnt = 0;
        end else if (m_booting) begin
            m_booting = 0;
        end else if (!m_faulted) begin
            if (b) begin
                m_v = 0;
                if (t % 4 == 0) m_pc = t;
                else m_faulted = 1;
            end else if (!s) begin
                m_instr = mem_word(m_pc);
                m_pc4   = m_pc + 32'd4;
                m_pc    = m_pc + 32'd4;
                m_v     = 1;
                if (m_cnt < 65535) m_cnt++;
            end
        end else begin
            m_v = 0;
        end
        e.addr = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
        e.en = !m_faulted; e.v = m_v; e.flt = m_faulted; e.cnt = m_cnt;
        @(posedge clk);
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("imem_addr",  imem_addr,  e.addr);
            chk("imem_en",    {31'd0, imem_en}, {31'd0, e.en});
            chk("fault",      {31'd0, fault}, {31'd0, e.flt});
            chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.v});
            if (e.v) chk("ifid_instr", ifid_instr, e.instr);
            chk("ifid_pc4",   ifid_pc4,   e.pc4);
            chk("fetch_cnt",  {16'd0, fetch_cnt}, e.cnt);
            chk("fetch_cnt_sat", {30'd0, fetch_cnt2}, (e.cnt > 3) ? 32'd3 : e.cnt);
        end
    end

    initial begin
        int stuck;
        rst_n = 0; stall = 0; branch_taken = 0; branch_target = 0;
        @(negedge clk); #1;

        // Reset, boot bubble, three deliveries
        cycle(0, 0, 0, 0);
        chk("rst_addr", imem_addr, 32'h0);
        cycle(1, 0, 0, 0);
        chk("boot_valid", {31'd0, ifid_valid}, 32'd0);
        repeat (3) cycle(1, 0, 0, 0);
        chk("seq_pc4", ifid_pc4, 32'd12);
        chk("seq_cnt", {16'd0, fetch_cnt}, 32'd3);
        chk("seq_addr", imem_addr, 32'd12);

        // Stall at PC=8
        cycle(0, 0, 0, 0);
        repeat (3) cycle(1, 0, 0, 0);
        repeat (3) cycle(1, 1, 0, 0);
        chk("stall_addr", imem_addr, 32'd8);
        chk("stall_pc4", ifid_pc4, 32'd8);
        cycle(1, 0, 0, 0);
        chk("unstall_pc4", ifid_pc4, 32'd12);

        // Branch with simultaneous stall at PC=16
        cycle(0, 0, 0, 0);
        repeat (5) cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 32'h40);
        chk("br_addr", imem_addr, 32'h40);
        chk("br_valid", {31'd0, ifid_valid}, 32'd0);
        chk("br_cnt", {16'd0, fetch_cnt}, 32'd4);
        cycle(1, 0, 0, 0);
        chk("br_pc4", ifid_pc4, 32'h44);

        // Misaligned branch -> sticky fault, cleared only by reset
        cycle(1, 0, 1, 32'h42);
        repeat (2) cycle(1, 0, 1, 32'h80);
        chk("flt_fault", {31'd0, fault}, 32'd1);
        chk("flt_en", {31'd0, imem_en}, 32'd0);
        cycle(0, 1, 1, 32'h80);
        chk("flt_clr", {31'd0, fault}, 32'd0);
        chk("flt_rst_addr", imem_addr, 32'h0);

        // Branch during boot is ignored; PC wrap
        cycle(1, 0, 1, 32'h80);
        chk("boot_br", imem_addr, 32'h0);
        cycle(1, 0, 1, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 0);
        chk("wrap_pc4", ifid_pc4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        repeat (4) cycle(1, 0, 0, 0);
        chk("sat_cnt", {30'd0, fetch_cnt2}, 32'd3);

        // Reset mid-stall
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);

        // Randomized traffic
        stuck = 0;
        for (int i = 0; i < 1500; i++) begin
            bit r, s, b;
            logic [31:0] t;
            r = ($urandom_range(39) != 0) && (stuck < 6);
            s = ($urandom_range(3) == 0);
            b = ($urandom_range(7) == 0);
            t = $urandom;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(9) == 0) t = 32'hFFFF_FFF0 | (t & 32'hC);
            stuck = m_faulted ? stuck + 1 : 0;
            cycle(r, s, b, t);
        end

        @(negedge clk); #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
